// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: word/register widths, EX/MEM data bundle and the
// data-memory request FSM state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        word_t    aluresult;
        word_t    upper16;
        word_t    rdat_two;
        word_t    pcplus4;
        regbits_t wsel;
        logic     regwrite;
        logic     memread;
        logic     memwrite;
        logic     lui;
        logic     jal;
        logic     valid;
    } exmem_t;

endpackage

// File: rtl/ex_mem_reg_if.sv
// Data-memory request bus between the EX/MEM register (master) and the
// data cache / memory (slave).
interface ex_mem_reg_if;
    import cpu_types_pkg::*;

    logic  dmemREN;
    logic  dmemWEN;
    logic  dhit;
    word_t dmemaddr;
    word_t dmemstore;

    modport master (output dmemREN, dmemWEN, dmemaddr, dmemstore, input dhit);
    modport slave  (input dmemREN, dmemWEN, dmemaddr, dmemstore, output dhit);

endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with data-memory request sequencing and a sticky
// halt that freezes the register once a valid halt has been captured.
//
//   state | meaning
//   IDLE  | no data-memory request outstanding
//   REQ   | dmemREN (load) or dmemWEN (store) asserted, waiting for dhit
//   DONE  | access served, holding results until the pipeline advances
module ex_mem_reg
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     stall,
    input  logic     flush,
    input  logic     dhit,
    input  word_t    aluresult_ex,
    input  logic [15:0] imm16_ex,
    input  word_t    rdat_two_id_ex_output,
    input  regbits_t wsel_ex,
    input  logic     regwrite_ex,
    input  logic     memread_ex,
    input  logic     memwrite_ex,
    input  logic     lui_ex,
    input  logic     jal_ex,
    input  logic     halt_ex,
    input  logic     valid_ex,
    input  word_t    pcplus4_ex,
    output word_t    aluresult_ex_mem_output,
    output word_t    upper16_ex_mem_output,
    output word_t    rdat_two_ex_mem_output,
    output word_t    pcplus4_ex_mem_output,
    output regbits_t wsel_ex_mem_output,
    output logic     regwrite_ex_mem_output,
    output logic     lui_ex_mem_output,
    output logic     jal_ex_mem_output,
    output logic     memread_ex_mem_output,
    output logic     halt_ex_mem_output,
    output logic     valid_ex_mem_output,
    output logic     dmemREN,
    output logic     dmemWEN,
    output logic     mem_stall
);

    mem_state_t state_q, state_d;
    exmem_t     exmem_q, exmem_d;
    exmem_t     capture;
    logic       halt_q, halt_d;
    logic       advance;

    assign mem_stall = (state_q == REQ) && !dhit;
    assign advance   = ihit && !stall && !mem_stall && !halt_q;

    // Control bits are qualified by valid so a bubble never carries side effects.
    always_comb begin
        capture           = '0;
        capture.aluresult = aluresult_ex;
        capture.upper16   = {imm16_ex, 16'h0000};
        capture.rdat_two  = rdat_two_id_ex_output;
        capture.pcplus4   = pcplus4_ex;
        capture.wsel      = wsel_ex;
        capture.regwrite  = regwrite_ex & valid_ex;
        capture.memread   = memread_ex  & valid_ex;
        capture.memwrite  = memwrite_ex & valid_ex;
        capture.lui       = lui_ex      & valid_ex;
        capture.jal       = jal_ex      & valid_ex;
        capture.valid     = valid_ex;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            exmem_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exmem_q <= exmem_d;
            halt_q  <= halt_d;
        end
    end

    // An advance takes priority over a same-cycle dhit so the next request wins.
    always_comb begin
        state_d = state_q;
        exmem_d = exmem_q;
        halt_d  = halt_q;
        if (advance) begin
            if (flush) begin
                exmem_d = '0;
                state_d = IDLE;
            end else begin
                exmem_d = capture;
                halt_d  = halt_q | (halt_ex & valid_ex);
                state_d = (capture.memread || capture.memwrite) ? REQ : IDLE;
            end
        end else begin
            case (state_q)
                REQ:     state_d = dhit ? DONE : REQ;
                DONE:    state_d = DONE;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign dmemREN = (state_q == REQ) && exmem_q.memread;
    assign dmemWEN = (state_q == REQ) && exmem_q.memwrite && !exmem_q.memread;

    assign aluresult_ex_mem_output = exmem_q.aluresult;
    assign upper16_ex_mem_output   = exmem_q.upper16;
    assign rdat_two_ex_mem_output  = exmem_q.rdat_two;
    assign pcplus4_ex_mem_output   = exmem_q.pcplus4;
    assign wsel_ex_mem_output      = exmem_q.wsel;
    assign regwrite_ex_mem_output  = exmem_q.regwrite;
    assign lui_ex_mem_output       = exmem_q.lui;
    assign jal_ex_mem_output       = exmem_q.jal;
    assign memread_ex_mem_output   = exmem_q.memread;
    assign valid_ex_mem_output     = exmem_q.valid;
    assign halt_ex_mem_output      = halt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for the EX/MEM register: ALU/LUI capture, load/store request
// sequencing, flush, stall, sticky halt and asynchronous reset.
module tb_ex_mem_reg;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST, ihit, stall, flush;
    word_t aluresult_ex, rdat_two_ex, pcplus4_ex;
    logic [15:0] imm16_ex;
    regbits_t wsel_ex;
    logic regwrite_ex, memread_ex, memwrite_ex, lui_ex, jal_ex, halt_ex, valid_ex;

    word_t aluresult_o, upper16_o, rdat_two_o, pcplus4_o;
    regbits_t wsel_o;
    logic regwrite_o, lui_o, jal_o, memread_o, halt_o, valid_o, mem_stall;

    int chk = 0;
    int err = 0;

    ex_mem_reg_if dif ();

    always #5 CLK = ~CLK;

    ex_mem_reg dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .flush(flush),
        .dhit(dif.dhit),
        .aluresult_ex(aluresult_ex), .imm16_ex(imm16_ex),
        .rdat_two_id_ex_output(rdat_two_ex), .wsel_ex(wsel_ex),
        .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
        .lui_ex(lui_ex), .jal_ex(jal_ex), .halt_ex(halt_ex), .valid_ex(valid_ex),
        .pcplus4_ex(pcplus4_ex),
        .aluresult_ex_mem_output(aluresult_o), .upper16_ex_mem_output(upper16_o),
        .rdat_two_ex_mem_output(rdat_two_o), .pcplus4_ex_mem_output(pcplus4_o),
        .wsel_ex_mem_output(wsel_o), .regwrite_ex_mem_output(regwrite_o),
        .lui_ex_mem_output(lui_o), .jal_ex_mem_output(jal_o),
        .memread_ex_mem_output(memread_o), .halt_ex_mem_output(halt_o),
        .valid_ex_mem_output(valid_o),
        .dmemREN(dif.dmemREN), .dmemWEN(dif.dmemWEN), .mem_stall(mem_stall)
    );

    assign dif.dmemaddr  = aluresult_o;
    assign dif.dmemstore = rdat_two_o;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ex();
        ihit = 0; stall = 0; flush = 0; dif.dhit = 0;
        aluresult_ex = '0; imm16_ex = '0; rdat_two_ex = '0; pcplus4_ex = '0; wsel_ex = '0;
        regwrite_ex = 0; memread_ex = 0; memwrite_ex = 0; lui_ex = 0; jal_ex = 0;
        halt_ex = 0; valid_ex = 0;
    endtask

    task automatic test_reset();
        clear_ex();
        nRST = 0;
        tick(); tick();
        chk++; if (aluresult_o !== 32'h0) begin err++; $display("FAIL reset_alu: got %h expected %h", aluresult_o, 32'h0); end
        chk++; if ({regwrite_o, valid_o, halt_o, memread_o} !== 4'b0) begin err++; $display("FAIL reset_ctrl: got %b expected 0000", {regwrite_o, valid_o, halt_o, memread_o}); end
        chk++; if ({dif.dmemREN, dif.dmemWEN, mem_stall} !== 3'b0) begin err++; $display("FAIL reset_mem: got %b expected 000", {dif.dmemREN, dif.dmemWEN, mem_stall}); end
        nRST = 1;
        tick();
    endtask

    task automatic test_alu();
        clear_ex();
        aluresult_ex = 32'h10; wsel_ex = 5'd8; regwrite_ex = 1; valid_ex = 1; ihit = 1;
        pcplus4_ex = 32'h404; jal_ex = 1;
        tick();
        ihit = 0;
        chk++; if (aluresult_o !== 32'h10) begin err++; $display("FAIL alu_result: got %h expected %h", aluresult_o, 32'h10); end
        chk++; if (wsel_o !== 5'd8) begin err++; $display("FAIL alu_wsel: got %0d expected 8", wsel_o); end
        chk++; if ({regwrite_o, valid_o, jal_o, dif.dmemREN} !== 4'b1110) begin err++; $display("FAIL alu_ctrl: got %b expected 1110", {regwrite_o, valid_o, jal_o, dif.dmemREN}); end
        chk++; if (pcplus4_o !== 32'h404) begin err++; $display("FAIL alu_pc4: got %h expected %h", pcplus4_o, 32'h404); end
    endtask

    task automatic test_lui();
        clear_ex();
        imm16_ex = 16'hABCD; lui_ex = 1; valid_ex = 1; ihit = 1;
        tick();
        ihit = 0;
        chk++; if (upper16_o !== 32'hABCD_0000) begin err++; $display("FAIL lui_upper: got %h expected %h", upper16_o, 32'hABCD_0000); end
        chk++; if (lui_o !== 1'b1) begin err++; $display("FAIL lui_flag: got %b expected 1", lui_o); end
    endtask

    task automatic test_load();
        clear_ex();
        aluresult_ex = 32'h100; memread_ex = 1; regwrite_ex = 1; wsel_ex = 5'd3; valid_ex = 1; ihit = 1;
        tick();
        aluresult_ex = 32'h999; memread_ex = 0; wsel_ex = 5'd9;
        for (int i = 0; i < 3; i++) begin
            chk++; if ({dif.dmemREN, mem_stall} !== 2'b11) begin err++; $display("FAIL load_wait%0d: got %b expected 11", i, {dif.dmemREN, mem_stall}); end
            chk++; if (aluresult_o !== 32'h100 || dif.dmemaddr !== 32'h100) begin err++; $display("FAIL load_hold%0d: got %h expected %h", i, aluresult_o, 32'h100); end
            tick();
        end
        ihit = 0; dif.dhit = 1;
        #1;
        chk++; if (mem_stall !== 1'b0) begin err++; $display("FAIL load_dhit_stall: got %b expected 0", mem_stall); end
        tick();
        dif.dhit = 0;
        chk++; if ({dif.dmemREN, mem_stall} !== 2'b00) begin err++; $display("FAIL load_done: got %b expected 00", {dif.dmemREN, mem_stall}); end
        chk++; if (aluresult_o !== 32'h100 || wsel_o !== 5'd3) begin err++; $display("FAIL load_done_hold: got %h/%0d expected %h/3", aluresult_o, wsel_o, 32'h100); end
    endtask

    task automatic test_back_to_back();
        clear_ex();
        aluresult_ex = 32'h180; memread_ex = 1; valid_ex = 1; ihit = 1;
        tick();
        aluresult_ex = 32'h200; memread_ex = 0; memwrite_ex = 1; rdat_two_ex = 32'hDEAD_BEEF;
        dif.dhit = 1;
        #1;
        chk++; if (mem_stall !== 1'b0) begin err++; $display("FAIL b2b_stall: got %b expected 0", mem_stall); end
        tick();
        ihit = 0; dif.dhit = 0;
        chk++; if ({dif.dmemREN, dif.dmemWEN} !== 2'b01) begin err++; $display("FAIL b2b_req: got %b expected 01", {dif.dmemREN, dif.dmemWEN}); end
        chk++; if (dif.dmemaddr !== 32'h200 || dif.dmemstore !== 32'hDEAD_BEEF) begin err++; $display("FAIL b2b_data: got %h/%h expected %h/%h", dif.dmemaddr, dif.dmemstore, 32'h200, 32'hDEAD_BEEF); end
        dif.dhit = 1;
        tick();
        dif.dhit = 0;
        chk++; if (dif.dmemWEN !== 1'b0) begin err++; $display("FAIL b2b_done: got %b expected 0", dif.dmemWEN); end
    endtask

    task automatic test_flush();
        clear_ex();
        aluresult_ex = 32'h1234; regwrite_ex = 1; memread_ex = 1; valid_ex = 1; flush = 1; ihit = 1;
        tick();
        ihit = 0; flush = 0;
        chk++; if ({regwrite_o, valid_o, dif.dmemREN, memread_o} !== 4'b0) begin err++; $display("FAIL flush_ctrl: got %b expected 0000", {regwrite_o, valid_o, dif.dmemREN, memread_o}); end
        chk++; if (aluresult_o !== 32'h0) begin err++; $display("FAIL flush_data: got %h expected %h", aluresult_o, 32'h0); end
    endtask

    task automatic test_stall();
        clear_ex();
        aluresult_ex = 32'hAAAA; wsel_ex = 5'd5; regwrite_ex = 1; valid_ex = 1; ihit = 1;
        tick();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            aluresult_ex = 32'hB000 + i; wsel_ex = 5'd20 + 5'(i);
            tick();
            chk++; if (aluresult_o !== 32'hAAAA || wsel_o !== 5'd5) begin err++; $display("FAIL stall_hold%0d: got %h/%0d expected %h/5", i, aluresult_o, wsel_o, 32'hAAAA); end
        end
        stall = 0; aluresult_ex = 32'hC0DE; wsel_ex = 5'd7;
        tick();
        ihit = 0;
        chk++; if (aluresult_o !== 32'hC0DE || wsel_o !== 5'd7) begin err++; $display("FAIL stall_resume: got %h/%0d expected %h/7", aluresult_o, wsel_o, 32'hC0DE); end
    endtask

    task automatic test_invalid();
        clear_ex();
        aluresult_ex = 32'h77; regwrite_ex = 1; memread_ex = 1; jal_ex = 1; valid_ex = 0; ihit = 1;
        tick();
        ihit = 0;
        chk++; if ({regwrite_o, memread_o, jal_o, valid_o, dif.dmemREN, mem_stall} !== 6'b0) begin err++; $display("FAIL invalid_ctrl: got %b expected 000000", {regwrite_o, memread_o, jal_o, valid_o, dif.dmemREN, mem_stall}); end
    endtask

    task automatic test_halt();
        clear_ex();
        aluresult_ex = 32'h55; halt_ex = 1; valid_ex = 1; ihit = 1;
        tick();
        halt_ex = 0; aluresult_ex = 32'h66; regwrite_ex = 1;
        chk++; if (halt_o !== 1'b1 || aluresult_o !== 32'h55) begin err++; $display("FAIL halt_set: got %b/%h expected 1/%h", halt_o, aluresult_o, 32'h55); end
        tick();
        flush = 1;
        tick();
        ihit = 0; flush = 0;
        chk++; if (halt_o !== 1'b1 || aluresult_o !== 32'h55 || regwrite_o !== 1'b0) begin err++; $display("FAIL halt_frozen: got %b/%h/%b expected 1/%h/0", halt_o, aluresult_o, regwrite_o, 32'h55); end
    endtask

    task automatic test_reset_mid_store();
        clear_ex();
        nRST = 0;
        #1;
        chk++; if (halt_o !== 1'b0) begin err++; $display("FAIL rst_halt_clear: got %b expected 0", halt_o); end
        tick();
        nRST = 1;
        aluresult_ex = 32'h300; memwrite_ex = 1; rdat_two_ex = 32'h1111; valid_ex = 1; ihit = 1;
        tick();
        ihit = 0;
        chk++; if (dif.dmemWEN !== 1'b1) begin err++; $display("FAIL store_req: got %b expected 1", dif.dmemWEN); end
        #2;
        nRST = 0;
        #1;
        chk++; if ({dif.dmemWEN, dif.dmemREN, mem_stall, valid_o, halt_o} !== 5'b0) begin err++; $display("FAIL rst_async: got %b expected 00000", {dif.dmemWEN, dif.dmemREN, mem_stall, valid_o, halt_o}); end
        chk++; if (aluresult_o !== 32'h0 || rdat_two_o !== 32'h0) begin err++; $display("FAIL rst_async_data: got %h/%h expected 0/0", aluresult_o, rdat_two_o); end
        tick();
        nRST = 1;
        clear_ex();
        aluresult_ex = 32'h42; wsel_ex = 5'd2; regwrite_ex = 1; valid_ex = 1; ihit = 1;
        tick();
        ihit = 0;
        chk++; if (aluresult_o !== 32'h42 || {regwrite_o, dif.dmemREN, dif.dmemWEN, mem_stall} !== 4'b1000) begin err++; $display("FAIL rst_first_adv: got %h/%b expected %h/1000", aluresult_o, {regwrite_o, dif.dmemREN, dif.dmemWEN, mem_stall}, 32'h42); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lui();
        test_load();
        test_back_to_back();
        test_flush();
        test_stall();
        test_invalid();
        test_halt();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
